// File: rtl/scope_capture_buffer.sv
// Circular sample-frame capture with pre-trigger history and edge trigger.
// Frozen record is streamed oldest-first over a valid/ready port.
module scope_capture_buffer #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int PRETRIG = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [1:0][11:0] samples,
  input  logic             arm,
  input  logic             abort,
  input  logic             force_trig,
  input  logic             trig_channel,
  input  logic             trig_rising,
  input  logic [11:0]      trig_level,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [23:0]      rd_data,
  output logic             rd_last,
  output logic             busy,
  output logic             triggered,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_READOUT
  } state_t;

  localparam logic [ADDR_W-1:0] LP_PRE  = ADDR_W'(PRETRIG);
  localparam logic [ADDR_W-1:0] LP_POST = ADDR_W'(DEPTH - PRETRIG - 1);
  localparam logic [ADDR_W-1:0] LP_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W-1:0]   r_pre_cnt;
  logic [ADDR_W-1:0]   r_post_cnt;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [ADDR_W-1:0]   r_rd_cnt;
  logic [11:0]         r_prev;
  logic                r_prev_valid;
  logic                r_force_pend;
  logic                r_issue;
  logic                r_rd_valid;
  logic [23:0]         r_rd_data;
  logic                r_rd_last;
  logic                r_triggered;
  logic [23:0]         r_mem [DEPTH];

  logic        w_capture;
  logic        w_wr_en;
  logic [11:0] w_cur;
  logic        w_above;
  logic        w_prev_above;
  logic        w_edge;
  logic        w_trig;
  logic        w_hs;

  assign w_capture    = (r_state == S_PREFILL) ||
                        (r_state == S_ARMED) ||
                        (r_state == S_POST);
  assign w_wr_en      = sample_valid && w_capture;
  assign w_cur        = trig_channel ? samples[1] : samples[0];
  assign w_above      = (w_cur >= trig_level);
  assign w_prev_above = (r_prev >= trig_level);
  assign w_edge       = r_prev_valid &&
                        (trig_rising ? (!w_prev_above && w_above)
                                     : (w_prev_above && !w_above));
  assign w_trig       = (r_state == S_ARMED) && w_wr_en &&
                        (w_edge || r_force_pend || force_trig);
  assign w_hs         = r_rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_wr_ptr] <= {samples[1], samples[0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_pre_cnt    <= '0;
      r_post_cnt   <= '0;
      r_rd_addr    <= '0;
      r_rd_cnt     <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_force_pend <= 1'b0;
      r_issue      <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_triggered  <= 1'b0;
    end else if (abort) begin
      r_state      <= S_IDLE;
      r_force_pend <= 1'b0;
      r_issue      <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_rd_last    <= 1'b0;
      r_triggered  <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr     <= r_wr_ptr + LP_ONE;
        r_prev       <= w_cur;
        r_prev_valid <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state      <= S_PREFILL;
            r_wr_ptr     <= '0;
            r_pre_cnt    <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
          end
        end
        S_PREFILL: begin
          if (LP_PRE == '0) begin
            r_state <= S_ARMED;
          end else if (w_wr_en) begin
            r_pre_cnt <= r_pre_cnt + LP_ONE;
            if (r_pre_cnt + LP_ONE == LP_PRE)
              r_state <= S_ARMED;
          end
        end
        S_ARMED: begin
          if (w_trig) begin
            r_state      <= S_POST;
            r_triggered  <= 1'b1;
            r_force_pend <= 1'b0;
            r_post_cnt   <= LP_POST;
            // record start: PRETRIG frames before the trigger frame
            r_rd_addr    <= r_wr_ptr - LP_PRE;
          end else if (force_trig) begin
            r_force_pend <= 1'b1;
          end
        end
        S_POST: begin
          if (r_post_cnt == '0) begin
            r_state  <= S_READOUT;
            r_issue  <= 1'b1;
            r_rd_cnt <= '0;
          end else if (w_wr_en) begin
            r_post_cnt <= r_post_cnt - LP_ONE;
            if (r_post_cnt == LP_ONE) begin
              r_state  <= S_READOUT;
              r_issue  <= 1'b1;
              r_rd_cnt <= '0;
            end
          end
        end
        S_READOUT: begin
          if (r_issue) begin
            r_rd_data  <= r_mem[r_rd_addr];
            r_rd_valid <= 1'b1;
            r_rd_last  <= (r_rd_cnt == LP_LAST);
            r_rd_addr  <= r_rd_addr + LP_ONE;
            r_issue    <= 1'b0;
          end else if (w_hs) begin
            r_rd_valid <= 1'b0;
            if (r_rd_last) begin
              r_state     <= S_IDLE;
              r_triggered <= 1'b0;
              r_rd_last   <= 1'b0;
              r_rd_data   <= '0;
            end else begin
              r_issue  <= 1'b1;
              r_rd_cnt <= r_rd_cnt + LP_ONE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_valid  = r_rd_valid && !abort;
  assign rd_data   = r_rd_data;
  assign rd_last   = r_rd_last;
  assign busy      = w_capture;
  assign triggered = r_triggered;
  assign done      = (r_state == S_READOUT);

endmodule

// File: tb/tb_scope_capture_buffer.sv
// Bench for scope_capture_buffer: two instances (PRETRIG=4 and PRETRIG=0),
// DEPTH=16, randomized frames against a frame-history reference model.
module tb_scope_capture_buffer;

  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_valid;
  logic [1:0][11:0] samples;
  logic             arm4, arm0;
  logic             abort;
  logic             force_trig;
  logic             trig_channel;
  logic             trig_rising;
  logic [11:0]      trig_level;
  logic             rd_ready;

  logic        rv4, rl4, bz4, tr4, dn4;
  logic [23:0] rd4;
  logic        rv0, rl0, bz0, tr0, dn0;
  logic [23:0] rd0;

  logic        sel;
  logic        rv, rl, bz, tr, dn;
  logic [23:0] rd;

  int checks = 0;
  int failures = 0;

  int          m_pre;
  int          m_trig_idx;
  logic        m_force_pend;
  logic [23:0] hist [$];

  scope_capture_buffer #(.DEPTH(DEPTH), .PRETRIG(4)) dut4 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .samples(samples), .arm(arm4), .abort(abort),
    .force_trig(force_trig), .trig_channel(trig_channel),
    .trig_rising(trig_rising), .trig_level(trig_level),
    .rd_ready(rd_ready), .rd_valid(rv4), .rd_data(rd4),
    .rd_last(rl4), .busy(bz4), .triggered(tr4), .done(dn4)
  );

  scope_capture_buffer #(.DEPTH(DEPTH), .PRETRIG(0)) dut0 (
    .clk(clk), .reset(reset), .sample_valid(sample_valid),
    .samples(samples), .arm(arm0), .abort(abort),
    .force_trig(force_trig), .trig_channel(trig_channel),
    .trig_rising(trig_rising), .trig_level(trig_level),
    .rd_ready(rd_ready), .rd_valid(rv0), .rd_data(rd0),
    .rd_last(rl0), .busy(bz0), .triggered(tr0), .done(dn0)
  );

  assign rv = sel ? rv0 : rv4;
  assign rd = sel ? rd0 : rd4;
  assign rl = sel ? rl0 : rl4;
  assign bz = sel ? bz0 : bz4;
  assign tr = sel ? tr0 : tr4;
  assign dn = sel ? dn0 : dn4;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rd_valid"}, 32'(rv), 0);
    check({tag, "_rd_data"}, 32'(rd), 0);
    check({tag, "_rd_last"}, 32'(rl), 0);
    check({tag, "_busy"}, 32'(bz), 0);
    check({tag, "_triggered"}, 32'(tr), 0);
    check({tag, "_done"}, 32'(dn), 0);
  endtask

  function automatic logic complete();
    return (m_trig_idx >= 0) &&
           (hist.size() == m_trig_idx + DEPTH - m_pre);
  endfunction

  task automatic setup(input logic s, input logic ch, input logic rise,
                       input logic [11:0] lvl);
    sel          = s;
    m_pre        = s ? 0 : 4;
    trig_channel = ch;
    trig_rising  = rise;
    trig_level   = lvl;
    hist.delete();
    m_trig_idx   = -1;
    m_force_pend = 1'b0;
  endtask

  task automatic do_arm();
    if (sel) arm0 = 1'b1;
    else arm4 = 1'b1;
    @(negedge clk);
    arm0 = 1'b0;
    arm4 = 1'b0;
    @(negedge clk);
    check("arm_busy", 32'(bz), 1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // One frame, then the model decides whether it is the trigger frame
  task automatic feed(input logic [11:0] a, input logic [11:0] b);
    int          i;
    logic [11:0] cur, prv;
    logic        edge_hit;
    sample_valid = 1'b1;
    samples[0]   = a;
    samples[1]   = b;
    @(negedge clk);
    sample_valid = 1'b0;
    hist.push_back({b, a});
    i = hist.size() - 1;
    if (m_trig_idx < 0 && i >= m_pre) begin
      edge_hit = 1'b0;
      if (i >= 1) begin
        cur = trig_channel ? hist[i][23:12] : hist[i][11:0];
        prv = trig_channel ? hist[i-1][23:12] : hist[i-1][11:0];
        edge_hit = trig_rising ? (prv < trig_level && cur >= trig_level)
                               : (prv >= trig_level && cur < trig_level);
      end
      if (edge_hit || m_force_pend) begin
        m_trig_idx   = i;
        m_force_pend = 1'b0;
      end
    end
    check("frame_triggered", 32'(tr), 32'(m_trig_idx >= 0));
    check("frame_busy", 32'(bz), 32'(!complete()));
    check("frame_done", 32'(dn), 32'(complete()));
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic run_capture(input int id, input int step);
    int          k = 0;
    logic [11:0] a, b;
    while (!complete() && k < 300) begin
      a = 12'($urandom_range(0, 4095));
      b = 12'($urandom_range(0, 4095));
      case (id)
        1: a = 12'((k % 16) * 100);
        2: b = (k < step) ? 12'($urandom_range(2048, 4095)) : 12'd10;
        3: a = (k < step) ? 12'($urandom_range(0, 999))
                          : 12'($urandom_range(1000, 4095));
        default: begin
          a = 12'd1000;
          if (k == step) begin
            force_trig = 1'b1;
            @(negedge clk);
            force_trig   = 1'b0;
            m_force_pend = 1'b1;
          end
        end
      endcase
      feed(a, b);
      k++;
    end
    check("capture_complete", 32'(complete()), 1);
  endtask

  task automatic readout(input int bp_at, input int n_stop);
    int          cnt = 0;
    int          cyc = 0;
    int          hold = 0;
    logic [23:0] exp;
    rd_ready = 1'b0;
    while (cnt < n_stop && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rv) begin
        exp = hist[m_trig_idx - m_pre + cnt];
        check("rd_data", 32'(rd), 32'(exp));
        check("rd_last", 32'(rl), 32'(cnt == DEPTH - 1));
        if (cnt == bp_at && hold < 5) begin
          rd_ready = 1'b0;
          hold++;
        end else begin
          rd_ready = ($urandom_range(0, 3) != 0);
          if (rd_ready) cnt++;
        end
      end else begin
        if (cnt == bp_at && hold > 0 && hold < 5)
          check("bp_valid_held", 32'(rv), 1);
        rd_ready = 1'($urandom_range(0, 1));
      end
    end
    check("readout_count", cnt, n_stop);
  endtask

  task automatic finish_readout(input string tag);
    @(negedge clk);
    rd_ready = 1'b0;
    check_idle(tag);
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    samples      = '0;
    arm4         = 1'b0;
    arm0         = 1'b0;
    abort        = 1'b0;
    force_trig   = 1'b0;
    trig_channel = 1'b0;
    trig_rising  = 1'b1;
    trig_level   = '0;
    rd_ready     = 1'b0;
    sel          = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset4");
    sel = 1'b1;
    #1 check_idle("reset0");
    reset = 1'b0;
    @(negedge clk);

    // rising ramp on A, backpressure on frame 3
    setup(1'b0, 1'b0, 1'b1, 12'd550);
    do_arm();
    run_capture(1, 0);
    readout(3, DEPTH);
    finish_readout("ramp_end");

    // falling step on B
    setup(1'b0, 1'b1, 1'b0, 12'd2048);
    do_arm();
    run_capture(2, 8);
    readout(-1, DEPTH);
    finish_readout("fall_end");

    // long ARMED period: ring wraps several times
    setup(1'b0, 1'b0, 1'b1, 12'd1000);
    do_arm();
    run_capture(3, 44);
    readout(-1, DEPTH);
    finish_readout("wrap_end");

    // force trigger on flat signal, PRETRIG=0
    setup(1'b1, 1'b0, 1'b1, 12'd1000);
    do_arm();
    run_capture(4, 3);
    readout(-1, DEPTH);
    finish_readout("force_end");

    // abort during POST, then clean re-arm
    setup(1'b1, 1'b0, 1'b1, 12'd1000);
    do_arm();
    feed(12'd0, 12'd0);
    feed(12'd0, 12'd0);
    feed(12'd0, 12'd0);
    feed(12'd2000, 12'd0);
    feed(12'd2000, 12'd0);
    pulse_abort();
    check_idle("abort_post");
    setup(1'b1, 1'b0, 1'b1, 12'd1000);
    do_arm();
    for (int i = 0; i < 5; i++) feed(12'd2000, 12'd0);
    pulse_abort();
    check_idle("abort_rearm");

    // async reset in the middle of a readout
    setup(1'b0, 1'b0, 1'b1, 12'd1000);
    do_arm();
    run_capture(3, 10);
    readout(-1, 5);
    rd_ready = 1'b0;
    #2 reset = 1'b1;
    #1 check_idle("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // clean capture after reset
    setup(1'b0, 1'b1, 1'b0, 12'd2048);
    do_arm();
    run_capture(2, 6);
    readout(2, DEPTH);
    finish_readout("after_reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
